xmem_bank_walker: RTL

- Inverse address engine for xmem. Given a partition, a physical bank and a window of bank-local offsets, it walks the bank and emits, per beat, the bank address and the global address that maps onto it.
- The global/bank mapping is the same SCALAR or ARRAY/CYCLIC mapping the forward bank-address calculation applies.
- Sits between the RISC-programmed partition tables and the flush/DMA-out logic, which must reconstruct global addresses when draining a bank.

---
 rtl/xmem_bank_walker_pkg.sv | 40 ++++
 rtl/xmem_bank2glb_adr.sv | 37 +++
 rtl/xmem_bank_walker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/xmem_bank_walker_pkg.sv
// xmem_bank_walker_pkg
// Shared xmem parameters for the bank walker: address width and partition
// table geometry, memory types with their bank counts, the walk command
// layout, the walker FSM states and the SCALAR word-term helper.
package xmem_bank_walker_pkg;

  localparam int XMEM_AW            = 16;
  localparam int MAX_PARTITION      = 4;
  localparam int LOG2_MAX_PARTITION = 2;
  localparam int XMEM_WALK_STEP_DEF = 4;

  typedef enum logic [0:0] {
    MEM_TYPE_SCALAR = 1'b0,
    MEM_TYPE_ARRAY  = 1'b1
  } xmem_mem_type_e;

  // Number of physical banks per memory type.
  localparam logic [XMEM_AW-1:0] BANK_NUM [2] = '{16'd4, 16'd8};

  typedef struct packed {
    logic [LOG2_MAX_PARTITION-1:0] partIdx;
    logic [3:0]                    bankIdx;
    logic [XMEM_AW-1:0]            offset;
    logic [15:0]                   len;
  } xmem_walk_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } walk_state_e;

  // ((loc >> 2) * BANK_NUM) << 2, modulo 2^XMEM_AW. The multiplier is a
  // constant, so this reduces to shifts and adds. It is only needed to seed
  // the walker's accumulator at command acceptance.
  function automatic logic [XMEM_AW-1:0] scalar_word_term(input logic [XMEM_AW-1:0] loc);
    return ((loc >> 2) * BANK_NUM[MEM_TYPE_SCALAR]) << 2;
  endfunction

endpackage

// File: rtl/xmem_bank2glb_adr.sv
// xmem_bank2glb_adr
// Combinational conversion of a bank-local byte offset to a global address
// for one mapping type.
//   loc_i         bank-local byte offset (relative to subBankStart)
//   word_term_i   SCALAR only: ((loc_i>>2)*BANK_NUM)<<2, supplied precomputed
//   bank_idx_i    SCALAR only: physical bank index
//   range_start_i ARRAY/CYCLIC only: subRangeStart of the partition
//   size_mask_i   ARRAY/CYCLIC only: subBankSize-1 of the partition
//   glb_adr_o     global address
module xmem_bank2glb_adr
  import xmem_bank_walker_pkg::*;
#(
  parameter string RANGE_TYPE = "SCALAR",
  parameter int    BANK_IDX_W = 4
) (
  input  logic [XMEM_AW-1:0]    loc_i,
  input  logic [XMEM_AW-1:0]    word_term_i,
  input  logic [BANK_IDX_W-1:0] bank_idx_i,
  input  logic [XMEM_AW-1:0]    range_start_i,
  input  logic [XMEM_AW-1:0]    size_mask_i,
  output logic [XMEM_AW-1:0]    glb_adr_o
);

  localparam bit IS_SCALAR = (RANGE_TYPE == "SCALAR");

  logic [XMEM_AW-1:0] scalar_adr;
  logic [XMEM_AW-1:0] array_adr;

  // The word term has its low two bits clear, so adding the bank index
  // (shifted) and OR-ing the byte lane are equivalent to additions.
  assign scalar_adr = word_term_i + (XMEM_AW'(bank_idx_i) << 2)
                    + {{(XMEM_AW-2){1'b0}}, loc_i[1:0]};
  assign array_adr  = range_start_i + (loc_i & size_mask_i);

  assign glb_adr_o  = IS_SCALAR ? scalar_adr : array_adr;

endmodule

// File: rtl/xmem_bank_walker.sv
// xmem_bank_walker
// Inverse xmem address engine: walks a window of bank-local offsets in one
// bank of a partition and emits, per beat, the bank address and the global
// address that maps onto it. Used by flush/DMA-out to rebuild global
// addresses while draining a bank.
//   clk, rst        clock, synchronous active-high reset
//   cmd_*           walk request (valid/ready), partition, bank, offset, len
//   abort           drop the remaining beats of the current walk
//   subRangeStart,
//   subBankStart,
//   subBankSize     flattened partition tables, XMEM_AW bits per partition
//   out_*           beat stream (valid/ready), global/bank address, last
//   done            one-cycle pulse when a walk ends (normal, abort, error)
//   err             one-cycle pulse when a request is rejected
module xmem_bank_walker
  import xmem_bank_walker_pkg::*;
#(
  parameter string RANGE_TYPE = "SCALAR",
  parameter int    BANK_IDX_W = 4,
  parameter int    LEN_W      = 16,
  parameter int    STEP       = XMEM_WALK_STEP_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [LOG2_MAX_PARTITION-1:0]    cmd_partIdx,
  input  logic [BANK_IDX_W-1:0]            cmd_bankIdx,
  input  logic [XMEM_AW-1:0]               cmd_offset,
  input  logic [LEN_W-1:0]                 cmd_len,
  input  logic                             abort,
  input  logic [MAX_PARTITION*XMEM_AW-1:0] subRangeStart,
  input  logic [MAX_PARTITION*XMEM_AW-1:0] subBankStart,
  input  logic [MAX_PARTITION*XMEM_AW-1:0] subBankSize,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XMEM_AW-1:0]               out_adr,
  output logic [XMEM_AW-1:0]               out_bankAdr,
  output logic                             out_last,
  output logic                             done,
  output logic                             err
);

  localparam bit IS_SCALAR = (RANGE_TYPE == "SCALAR");
  localparam int STEP_SH   = $clog2(STEP);
  localparam int OVF_W     = XMEM_AW + LEN_W + 4;

  walk_state_e               state_q, state_d;
  logic [XMEM_AW-1:0]        loc_q, loc_d;
  logic [XMEM_AW-1:0]        word_q, word_d;
  logic [XMEM_AW-1:0]        bank_start_q, bank_start_d;
  logic [XMEM_AW-1:0]        range_start_q, range_start_d;
  logic [XMEM_AW-1:0]        size_mask_q, size_mask_d;
  logic [BANK_IDX_W-1:0]     bank_idx_q, bank_idx_d;
  logic [LEN_W-1:0]          rem_q, rem_d;
  logic                      err_q, err_d;

  logic [XMEM_AW-1:0]        tbl_range_start;
  logic [XMEM_AW-1:0]        tbl_bank_start;
  logic [XMEM_AW-1:0]        tbl_bank_size;
  logic [OVF_W-1:0]          walk_end;
  logic                      walk_ovf;
  logic [XMEM_AW-1:0]        loc_nxt;
  logic                      word_cross;
  logic                      hs;
  logic [XMEM_AW-1:0]        glb_adr;

  // Table entries of the requested partition, captured at acceptance.
  assign tbl_range_start = subRangeStart[cmd_partIdx*XMEM_AW +: XMEM_AW];
  assign tbl_bank_start  = subBankStart[cmd_partIdx*XMEM_AW +: XMEM_AW];
  assign tbl_bank_size   = subBankSize[cmd_partIdx*XMEM_AW +: XMEM_AW];

  // Window end computed wide enough that offset+len*STEP cannot wrap.
  assign walk_end = OVF_W'(cmd_offset) + (OVF_W'(cmd_len) << STEP_SH);
  assign walk_ovf = !IS_SCALAR && (walk_end > OVF_W'(tbl_bank_size));

  assign hs         = out_valid && out_ready;
  assign loc_nxt    = loc_q + XMEM_AW'(STEP);
  // STEP <= 4, so one advance crosses at most one 32-bit word boundary.
  assign word_cross = (loc_nxt[XMEM_AW-1:2] != loc_q[XMEM_AW-1:2]);

  always_comb begin
    state_d       = state_q;
    loc_d         = loc_q;
    word_d        = word_q;
    bank_start_d  = bank_start_q;
    range_start_d = range_start_q;
    size_mask_d   = size_mask_q;
    bank_idx_d    = bank_idx_q;
    rem_d         = rem_q;
    err_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          bank_start_d  = tbl_bank_start;
          range_start_d = tbl_range_start;
          size_mask_d   = tbl_bank_size - XMEM_AW'(1);
          bank_idx_d    = cmd_bankIdx;
          loc_d         = cmd_offset;
          word_d        = scalar_word_term(cmd_offset);
          rem_d         = cmd_len;
          if (cmd_len == '0) begin
            state_d = FIN;
          end else if (walk_ovf) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (hs) begin
          loc_d = loc_nxt;
          rem_d = rem_q - LEN_W'(1);
          if (word_cross) begin
            word_d = word_q + (BANK_NUM[MEM_TYPE_SCALAR] << 2);
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = FIN;
          end
        end
        // A beat handshaken together with abort has already been counted.
        if (abort) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Walk state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      loc_q         <= '0;
      word_q        <= '0;
      bank_start_q  <= '0;
      range_start_q <= '0;
      size_mask_q   <= '0;
      bank_idx_q    <= '0;
      rem_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      loc_q         <= loc_d;
      word_q        <= word_d;
      bank_start_q  <= bank_start_d;
      range_start_q <= range_start_d;
      size_mask_q   <= size_mask_d;
      bank_idx_q    <= bank_idx_d;
      rem_q         <= rem_d;
      err_q         <= err_d;
    end
  end

  xmem_bank2glb_adr #(
    .RANGE_TYPE (RANGE_TYPE),
    .BANK_IDX_W (BANK_IDX_W)
  ) u_bank2glb (
    .loc_i         (loc_q),
    .word_term_i   (word_q),
    .bank_idx_i    (bank_idx_q),
    .range_start_i (range_start_q),
    .size_mask_i   (size_mask_q),
    .glb_adr_o     (glb_adr)
  );

  // Beat outputs are decoded from registers only, so they stay stable while
  // the consumer stalls; addresses read zero outside a beat.
  assign cmd_ready   = (state_q == IDLE);
  assign out_valid   = (state_q == RUN);
  assign out_last    = out_valid && (rem_q == LEN_W'(1));
  assign out_bankAdr = out_valid ? (bank_start_q + loc_q) : '0;
  assign out_adr     = out_valid ? glb_adr : '0;
  assign done        = (state_q == FIN);
  assign err         = err_q;

endmodule
